// File: rtl/wrap_event_bcd_counter.sv
// rtl/wrap_event_bcd_counter.sv - two-digit BCD event counter on rising edges of z with seven-segment outputs
module wrap_event_bcd_counter #(
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int MAX_TENS       = 9
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       z,
  input  logic       hold,
  input  logic       clr,
  output logic [3:0] bcd_ones,
  output logic [3:0] bcd_tens,
  output logic       ovf,
  output logic       inc,
  output logic [6:0] seg_ones,
  output logic [6:0] seg_tens
);

  localparam logic [3:0] MAX_T = 4'(MAX_TENS);

  // {g,f,e,d,c,b,a}; non-BCD codes blank the digit
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] p;
    case (d)
      4'd0:    p = 7'b1000000;
      4'd1:    p = 7'b1111001;
      4'd2:    p = 7'b0100100;
      4'd3:    p = 7'b0110000;
      4'd4:    p = 7'b0011001;
      4'd5:    p = 7'b0010010;
      4'd6:    p = 7'b0000010;
      4'd7:    p = 7'b1111000;
      4'd8:    p = 7'b0000000;
      4'd9:    p = 7'b0010000;
      default: p = 7'b1111111;
    endcase
    return (SEG_ACTIVE_LOW != 0) ? p : ~p;
  endfunction

  localparam logic [6:0] SEG_ZERO = (SEG_ACTIVE_LOW != 0) ? 7'b1000000 : 7'b0111111;

  logic       z_d;
  logic       edge_det;
  logic [3:0] ones_nxt;
  logic [3:0] tens_nxt;
  logic       wrap;

  assign edge_det = z & ~z_d;

  // Incremented digit values; wrap means the count rolls from the maximum to 00
  always_comb begin
    ones_nxt = bcd_ones;
    tens_nxt = bcd_tens;
    wrap     = 1'b0;
    if (bcd_ones != 4'd9) begin
      ones_nxt = bcd_ones + 4'd1;
    end else if (bcd_tens != MAX_T) begin
      ones_nxt = 4'd0;
      tens_nxt = bcd_tens + 4'd1;
    end else begin
      ones_nxt = 4'd0;
      tens_nxt = 4'd0;
      wrap     = 1'b1;
    end
  end

  // Previous-z tracking runs every cycle, independent of hold and clr
  always_ff @(posedge clk or posedge reset) begin
    if (reset) z_d <= 1'b0;
    else       z_d <= z;
  end

  // Count register with clr > hold > edge priority
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bcd_ones <= 4'd0;
      bcd_tens <= 4'd0;
      ovf      <= 1'b0;
      inc      <= 1'b0;
    end else if (clr) begin
      bcd_ones <= 4'd0;
      bcd_tens <= 4'd0;
      ovf      <= 1'b0;
      inc      <= 1'b0;
    end else if (hold) begin
      inc      <= 1'b0;
    end else if (edge_det) begin
      bcd_ones <= ones_nxt;
      bcd_tens <= tens_nxt;
      ovf      <= ovf | wrap;
      inc      <= 1'b1;
    end else begin
      inc      <= 1'b0;
    end
  end

  // Segment patterns trail the digit registers by one stage
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg_ones <= SEG_ZERO;
      seg_tens <= SEG_ZERO;
    end else begin
      seg_ones <= seg_decode(bcd_ones);
      seg_tens <= seg_decode(bcd_tens);
    end
  end

endmodule

// File: tb/tb_wrap_event_bcd_counter.sv
// tb/tb_wrap_event_bcd_counter.sv - self-checking bench for wrap_event_bcd_counter
module tb_wrap_event_bcd_counter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       z = 1'b0;
  logic       hold = 1'b0;
  logic       clr = 1'b0;
  logic [3:0] bcd_ones;
  logic [3:0] bcd_tens;
  logic       ovf;
  logic       inc;
  logic [6:0] seg_ones;
  logic [6:0] seg_tens;

  int pass_cnt = 0;
  int total_cnt = 0;

  wrap_event_bcd_counter #(.SEG_ACTIVE_LOW(1), .MAX_TENS(9)) dut (
    .clk(clk), .reset(reset), .z(z), .hold(hold), .clr(clr),
    .bcd_ones(bcd_ones), .bcd_tens(bcd_tens), .ovf(ovf), .inc(inc),
    .seg_ones(seg_ones), .seg_tens(seg_tens)
  );

  always #10 clk = ~clk;

  // display patterns per digit value, active-low
  logic [6:0] seg_tbl [0:9];
  initial begin
    seg_tbl[0] = 7'b1000000; seg_tbl[1] = 7'b1111001; seg_tbl[2] = 7'b0100100;
    seg_tbl[3] = 7'b0110000; seg_tbl[4] = 7'b0011001; seg_tbl[5] = 7'b0010010;
    seg_tbl[6] = 7'b0000010; seg_tbl[7] = 7'b1111000; seg_tbl[8] = 7'b0000000;
    seg_tbl[9] = 7'b0010000;
  end

  // model: count as an integer 0..99, previous z, segment view of last cycle's count
  int         m_cnt = 0;
  bit         m_ovf = 0;
  bit         m_inc = 0;
  bit         m_zd = 0;
  logic [6:0] m_so = 7'b1000000;
  logic [6:0] m_st = 7'b1000000;
  int         inc_seen = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_cnt = 0; m_ovf = 0; m_inc = 0; m_zd = 0;
      m_so = 7'b1000000; m_st = 7'b1000000;
    end else begin
      m_so = seg_tbl[m_cnt % 10];
      m_st = seg_tbl[m_cnt / 10];
      if (clr) begin
        m_cnt = 0; m_ovf = 0; m_inc = 0;
      end else if (hold) begin
        m_inc = 0;
      end else if (z && !m_zd) begin
        if (m_cnt == 99) begin m_cnt = 0; m_ovf = 1; end
        else m_cnt = m_cnt + 1;
        m_inc = 1;
      end else begin
        m_inc = 0;
      end
      m_zd = z;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // per-cycle comparison against the model
  always @(negedge clk) begin
    check("ones", int'(bcd_ones), m_cnt % 10);
    check("tens", int'(bcd_tens), m_cnt / 10);
    check("ovf", int'(ovf), int'(m_ovf));
    check("inc", int'(inc), int'(m_inc));
    check("seg_ones", int'(seg_ones), int'(m_so));
    check("seg_tens", int'(seg_tens), int'(m_st));
    if (inc) inc_seen++;
  end

  task automatic step(input bit zv);
    @(negedge clk); #1;
    z = zv;
  endtask

  task automatic pulse(input int hi);
    for (int i = 0; i < hi; i++) step(1'b1);
    step(1'b0);
    step(1'b0);
  endtask

  task automatic pin(input string name, input int tens, input int ones, input bit ov);
    check({name, "_tens"}, int'(bcd_tens), tens);
    check({name, "_ones"}, int'(bcd_ones), ones);
    check({name, "_ovf"}, int'(ovf), int'(ov));
  endtask

  int  c2;
  bit  x;

  initial begin
    #50;
    pin("rst", 0, 0, 0);
    check("rst_seg", int'(seg_ones), 7'b1000000);
    @(negedge clk); #1;
    reset = 1'b0;

    // 1-cycle and 4-cycle pulses -> 02, two inc cycles
    inc_seen = 0;
    pulse(1);
    pulse(4);
    @(negedge clk); #1;
    pin("two", 0, 2, 0);
    check("inc_total", inc_seen, 2);
    check("seg_two", int'(seg_ones), 7'b0100100);

    // up to 99, wrap, one more
    for (int i = 0; i < 97; i++) pulse(1);
    pin("n99", 9, 9, 0);
    step(1'b1);
    @(negedge clk);
    pin("wrap", 0, 0, 1);
    check("wrap_inc", int'(inc), 1);
    #1; z = 1'b0;
    pulse(1);
    pin("after", 0, 1, 1);

    // hold masks edges; release with z high does not count
    hold = 1'b1;
    pulse(2); pulse(1);
    step(1'b1); step(1'b1);
    check("hold_inc", int'(inc), 0);
    hold = 1'b0;
    step(1'b1); step(1'b1);
    pin("hold", 0, 1, 1);
    step(1'b0);
    pulse(1);
    pin("hold_next", 0, 2, 1);

    // clr wins over a simultaneous edge
    for (int i = 0; i < 35; i++) pulse(1);
    pin("n37", 3, 7, 1);
    @(negedge clk); #1;
    clr = 1'b1; z = 1'b1;
    @(negedge clk); #1;
    clr = 1'b0;
    step(1'b1); step(1'b1);
    pin("clr", 0, 0, 0);
    check("clr_inc", int'(inc), 0);
    step(1'b0);

    // asynchronous reset from 58
    for (int i = 0; i < 58; i++) pulse(1);
    pin("n58", 5, 8, 0);
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    pin("arst", 0, 0, 0);
    check("arst_seg_o", int'(seg_ones), 7'b1000000);
    check("arst_seg_t", int'(seg_tens), 7'b1000000);
    @(negedge clk); #1;
    reset = 1'b0;

    // driven by a two-bit counter, x toggling every cycle, z = terminal count
    c2 = 0; x = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #1;
      x = ~x;
      if (x) c2 = (c2 + 1) % 4;
      z = (c2 == 3);
    end
    @(negedge clk); #1;
    z = 1'b0;
    @(negedge clk);
    check("chain_cnt", int'(bcd_tens) * 10 + int'(bcd_ones), 12);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/wrap_event_bcd_counter.md
Name: wrap_event_bcd_counter

Overview:
- Sits directly downstream of the two-bit counter and consumes its terminal-count output z.
- Counts rising edges of z in a two-digit BCD counter (00–99) with a sticky overflow flag.
- Drives registered active-low seven-segment patterns for the board display.
- All flops run on the same clk/reset as the two-bit counter.

Parameters:
- SEG_ACTIVE_LOW, 1, 1: segment outputs are active-low (common anode); 0: active-high.
- MAX_TENS, 9, tens digit value at which the count wraps; the legal range is 1–9.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- z  input  1  terminal-count level from the two-bit counter; may stay high for several cycles.
- hold  input  1  when 1, edges are ignored and the count freezes; edge tracking continues.
- clr  input  1  synchronous clear of the count and the overflow flag.
- bcd_ones  output  4  ones digit, 0–9.
- bcd_tens  output  4  tens digit, 0–MAX_TENS.
- ovf  output  1  sticky; set when the count wraps from the maximum to 00.
- inc  output  1  one-cycle pulse; high in the cycle in which the count has just changed.
- seg_ones  output  7  {g,f,e,d,c,b,a} pattern for bcd_ones.
- seg_tens  output  7  {g,f,e,d,c,b,a} pattern for bcd_tens.

Behaviour:
- Reset (asynchronous, active-high) forces:
  - bcd_ones=0, bcd_tens=0, ovf=0, inc=0.
  - z_d (previous-z register) = 0.
  - seg_ones and seg_tens = the "0" pattern: 7'b1000000 when SEG_ACTIVE_LOW=1, else 7'b0111111.
- Edge detect: edge = z & ~z_d, evaluated at each rising clk edge. z_d <= z every cycle, regardless of hold or clr.
- Consequence of z_d resetting to 0: if z is already 1 at the first clock after reset is released, that clock counts as an edge.
- Priority at each rising edge: clr > hold > edge.
  - clr=1: digits <= 0, ovf <= 0, inc <= 0. A simultaneous edge is discarded.
  - hold=1 (clr=0): digits and ovf unchanged, inc <= 0. An edge during hold is lost, not deferred.
  - edge=1 (clr=0, hold=0): increment the count and set inc <= 1.
  - Otherwise: inc <= 0.
- Increment rules:
  - ones<9: ones+1.
  - ones=9 and tens<MAX_TENS: ones=0, tens+1.
  - ones=9 and tens=MAX_TENS: ones=0, tens=0, ovf <= 1. ovf remains 1 until clr or reset.
- Latency:
  - z rises and is first sampled at clk edge k: bcd and inc update at edge k.
  - seg_* reflect the new digits after edge k+1 (one register stage after the BCD registers).
  - inc is high for exactly one cycle per counted edge.
- z held high for N cycles produces exactly one count. z must be low for at least one sampled cycle before the next edge counts.
- Segment decode, active-low values:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Values 10–15 are unreachable; if they ever occur, output all segments off.
  - When SEG_ACTIVE_LOW=0, output the bitwise inverse of these patterns.
- Reset asserted mid-operation: all outputs return to reset values immediately, without waiting for clk. The count restarts from 00 after release.
- Digits never leave the BCD range. There is no intermediate state with ones=10.

Test Plan:
- Reset held 50 ns, z=0 -> bcd=00, ovf=0, inc=0, seg_ones=seg_tens=1000000 throughout.
- z pulsed high for 1 cycle, then for 4 cycles, each separated by low periods -> count 00→01→02. inc is high for exactly 2 total cycles. seg_ones=0100100 one cycle after bcd_ones=2.
- 99 isolated z pulses -> bcd_tens=9, bcd_ones=9, ovf=0. One more pulse -> bcd=00, ovf=1, inc=1. A further pulse -> 01 with ovf still 1.
- hold=1 during 3 z pulses -> count unchanged, inc stays 0. hold=0 with z already high (no new edge) -> no count. The next z rise -> count+1.
- Count at 37 with ovf=1; clr=1 in the same cycle as a z rise -> bcd=00, ovf=0, inc=0. The edge is not counted after clr is released.
- Count at 58; reset asserted between clock edges -> outputs go to 00 / 1000000 / ovf=0 before the next clk edge.
- Connected to the two-bit counter (clk period 20 ns, x toggling every 20 ns) -> count increments once per z rise of the counter, and bcd matches an independent model over 2000 ns.
